// File: rtl/vga_layer_compositor.sv
// -----------------------------------------------------------------------------
// vga_layer_compositor
//
// Purpose:
//   Generates 640x480-class VGA timing and composites NUM_SPRITES rectangular,
//   ROM-backed sprite layers over a background colour. Layer 0 has the highest
//   priority. A sprite pixel equal to KEY_COLOR is transparent. Each sprite
//   carries a per-scene visibility mask. Sprite geometry and masks are written
//   into shadow registers at any time. They are copied into the active set
//   atomically at the end of every frame, together with the scene selector.
//
// Pipeline (cycle t = cycle in which hcnt/vcnt address a pixel):
//   t+1           hit flags and sprite ROM addresses registered
//   t+1+ROM_LAT   ROM BGR data returns, composite evaluated
//   t+2+ROM_LAT   colour, sync and blank registered on the outputs
//
// Ports:
//   iVGA_CLK      pixel clock
//   iRST          asynchronous active-high reset
//   scene_sel     current scene, latched at frame commit
//   cfg_we        one-cycle config write strobe
//   cfg_sprite    target sprite index (out-of-range writes are ignored)
//   cfg_field     0=x0 1=y0 2=w 3=h 4=scene mask (others ignored)
//   cfg_data      write value; the mask uses the low NUM_SCENES bits
//   spr_addr      per-sprite ROM address, sprite i at [i*AW +: AW]
//   spr_bgr       per-sprite ROM BGR data, sprite i at [i*24 +: 24]
//   oHS/oVS       active-low syncs, aligned with the colour outputs
//   oBLANK_n      high during active video, aligned with the colour outputs
//   b/g/r_data    pixel colour, BGR[23:16] / [15:8] / [7:0]
//   frame_start   one-cycle pulse coinciding with the commit cycle
// -----------------------------------------------------------------------------
module vga_layer_compositor #(
    parameter int          NUM_SPRITES = 6,
    parameter int          AW          = 19,
    parameter int          NUM_SCENES  = 4,
    parameter int          ROM_LAT     = 2,
    parameter int          H_ACTIVE    = 640,
    parameter int          H_FRONT     = 16,
    parameter int          H_SYNC      = 96,
    parameter int          H_BACK      = 48,
    parameter int          V_ACTIVE    = 480,
    parameter int          V_FRONT     = 10,
    parameter int          V_SYNC      = 2,
    parameter int          V_BACK      = 33,
    parameter logic [23:0] BG_COLOR    = 24'h150088,
    parameter logic [23:0] KEY_COLOR   = 24'hFF00FF
) (
    input  logic                      iVGA_CLK,
    input  logic                      iRST,
    input  logic [31:0]               scene_sel,
    input  logic                      cfg_we,
    input  logic [7:0]                cfg_sprite,
    input  logic [2:0]                cfg_field,
    input  logic [15:0]               cfg_data,
    output logic [NUM_SPRITES*AW-1:0] spr_addr,
    input  logic [NUM_SPRITES*24-1:0] spr_bgr,
    output logic                      oHS,
    output logic                      oVS,
    output logic                      oBLANK_n,
    output logic [7:0]                b_data,
    output logic [7:0]                g_data,
    output logic [7:0]                r_data,
    output logic                      frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DLY     = ROM_LAT + 2;
    localparam int SIW     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int SCW     = (NUM_SCENES > 1) ? $clog2(NUM_SCENES) : 1;

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_PRE_C  = HW'(H_TOTAL - 2);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
    localparam logic [7:0]    NSPR_C   = 8'(NUM_SPRITES);
    localparam logic [31:0]   NSCN_C   = 32'(NUM_SCENES);

    // raster counters
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;

    // shadow (write side) and active (display side) sprite configuration
    logic [15:0]           r_sh_x0   [NUM_SPRITES];
    logic [15:0]           r_sh_y0   [NUM_SPRITES];
    logic [15:0]           r_sh_w    [NUM_SPRITES];
    logic [15:0]           r_sh_h    [NUM_SPRITES];
    logic [NUM_SCENES-1:0] r_sh_mask [NUM_SPRITES];
    logic [15:0]           r_x0      [NUM_SPRITES];
    logic [15:0]           r_y0      [NUM_SPRITES];
    logic [15:0]           r_w       [NUM_SPRITES];
    logic [15:0]           r_h       [NUM_SPRITES];
    logic [NUM_SCENES-1:0] r_mask    [NUM_SPRITES];
    logic [31:0]           r_scene;

    // pipeline state
    logic [NUM_SPRITES-1:0]    r_hit_dl [ROM_LAT+1];
    logic [NUM_SPRITES*AW-1:0] r_spr_addr;
    logic [DLY-1:0]            r_act_dl;
    logic [DLY-1:0]            r_hs_dl;
    logic [DLY-1:0]            r_vs_dl;
    logic [23:0]               r_rgb;
    logic                      r_frame_start;

    // combinational helpers
    logic                   w_active;
    logic                   w_hs;
    logic                   w_vs;
    logic                   w_commit;
    logic                   w_pre_commit;
    logic                   w_cfg_ok;
    logic [SIW-1:0]         w_cfg_idx;
    logic [NUM_SPRITES-1:0] w_hit;
    logic [AW-1:0]          w_addr [NUM_SPRITES];
    logic [23:0]            w_pix;
    logic                   w_found;

    assign w_active     = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
    assign w_hs         = !((r_hcnt >= HS_BEG_C) && (r_hcnt < HS_END_C));
    assign w_vs         = !((r_vcnt >= VS_BEG_C) && (r_vcnt < VS_END_C));
    assign w_commit     = (r_hcnt == H_LAST_C) && (r_vcnt == V_LAST_C);
    assign w_pre_commit = (r_hcnt == H_PRE_C) && (r_vcnt == V_LAST_C);
    assign w_cfg_ok     = cfg_we && (cfg_sprite < NSPR_C) && (cfg_field <= 3'd4);
    assign w_cfg_idx    = cfg_sprite[SIW-1:0];

    // Per-sprite hit test and linear ROM address for the current raster
    // position. Bounds are widened to 17 bits so x0+w / y0+h cannot wrap.
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_spr
        logic [16:0] w_h17;
        logic [16:0] w_v17;
        logic [16:0] w_x_beg;
        logic [16:0] w_x_end;
        logic [16:0] w_y_beg;
        logic [16:0] w_y_end;
        logic        w_en;

        assign w_h17   = 17'(r_hcnt);
        assign w_v17   = 17'(r_vcnt);
        assign w_x_beg = {1'b0, r_x0[gi]};
        assign w_x_end = {1'b0, r_x0[gi]} + {1'b0, r_w[gi]};
        assign w_y_beg = {1'b0, r_y0[gi]};
        assign w_y_end = {1'b0, r_y0[gi]} + {1'b0, r_h[gi]};
        // A scene number beyond the mask width disables every sprite.
        assign w_en    = (r_scene < NSCN_C) && r_mask[gi][r_scene[SCW-1:0]];
        assign w_hit[gi] = w_active && w_en &&
                           (w_h17 >= w_x_beg) && (w_h17 < w_x_end) &&
                           (w_v17 >= w_y_beg) && (w_v17 < w_y_end);
        assign w_addr[gi] = AW'((32'(16'(r_vcnt) - r_y0[gi]) * 32'(r_w[gi])) +
                                32'(16'(r_hcnt) - r_x0[gi]));
    end

    // Raster counters: hcnt wraps at H_TOTAL, vcnt advances on each hcnt wrap.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == H_LAST_C) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_LAST_C) ? '0 : r_vcnt + VW'(1);
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    // Shadow register writes; a write on the commit cycle lands here only.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_sh_x0[i]   <= 16'd0;
                r_sh_y0[i]   <= 16'd0;
                r_sh_w[i]    <= 16'd0;
                r_sh_h[i]    <= 16'd0;
                r_sh_mask[i] <= '0;
            end
        end else if (w_cfg_ok) begin
            case (cfg_field)
                3'd0:    r_sh_x0[w_cfg_idx]   <= cfg_data;
                3'd1:    r_sh_y0[w_cfg_idx]   <= cfg_data;
                3'd2:    r_sh_w[w_cfg_idx]    <= cfg_data;
                3'd3:    r_sh_h[w_cfg_idx]    <= cfg_data;
                3'd4:    r_sh_mask[w_cfg_idx] <= cfg_data[NUM_SCENES-1:0];
                default: ;
            endcase
        end
    end

    // Frame-end commit of shadow config and scene selection.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_x0[i]   <= 16'd0;
                r_y0[i]   <= 16'd0;
                r_w[i]    <= 16'd0;
                r_h[i]    <= 16'd0;
                r_mask[i] <= '0;
            end
            r_scene <= 32'd0;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_x0[i]   <= r_sh_x0[i];
                r_y0[i]   <= r_sh_y0[i];
                r_w[i]    <= r_sh_w[i];
                r_h[i]    <= r_sh_h[i];
                r_mask[i] <= r_sh_mask[i];
            end
            r_scene <= scene_sel;
        end
    end

    // frame_start is registered one cycle early so it is high on the commit cycle itself.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_pre_commit;
        end
    end

    // Stage 1: sprite addresses (held on a miss) and the hit-flag delay line
    // that lines hits up with the returning ROM data.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_spr_addr <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                r_hit_dl[k] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (w_hit[i]) begin
                    r_spr_addr[i*AW +: AW] <= w_addr[i];
                end
            end
            r_hit_dl[0] <= w_hit;
            for (int k = 1; k <= ROM_LAT; k++) begin
                r_hit_dl[k] <= r_hit_dl[k-1];
            end
        end
    end

    // Sync and blank delay lines matching the colour path latency.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_act_dl <= '0;
            r_hs_dl  <= '1;
            r_vs_dl  <= '1;
        end else begin
            r_act_dl <= {r_act_dl[DLY-2:0], w_active};
            r_hs_dl  <= {r_hs_dl[DLY-2:0], w_hs};
            r_vs_dl  <= {r_vs_dl[DLY-2:0], w_vs};
        end
    end

    // Priority composite: lowest-index opaque hit wins, else background/black.
    always_comb begin
        w_pix   = r_act_dl[ROM_LAT] ? BG_COLOR : 24'h000000;
        w_found = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (!w_found && r_hit_dl[ROM_LAT][i] && (spr_bgr[i*24 +: 24] != KEY_COLOR)) begin
                w_pix   = spr_bgr[i*24 +: 24];
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Output colour register.
    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            r_rgb <= 24'h000000;
        end else begin
            r_rgb <= w_pix;
        end
    end

    assign spr_addr    = r_spr_addr;
    assign oHS         = r_hs_dl[DLY-1];
    assign oVS         = r_vs_dl[DLY-1];
    assign oBLANK_n    = r_act_dl[DLY-1];
    assign b_data      = r_rgb[23:16];
    assign g_data      = r_rgb[15:8];
    assign r_data      = r_rgb[7:0];
    assign frame_start = r_frame_start;

endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
- Parametrised successor to the single-scene VGA pixel path. Generates its own 640x480-class timing.
- Composites NUM_SPRITES rectangular ROM-backed sprite layers over a background colour, with a fixed priority order, a transparency key and per-scene visibility masks.
- Sprite positions, sizes and masks are runtime-writable and commit atomically at frame end.
- Sits between the processor's scene register and the VGA DAC. Sprite ROM pairs (data + index) are instantiated outside the block and connected through address and data buses.

Parameters:
- NUM_SPRITES, 6, number of sprite layers; layer 0 has highest priority
- AW, 19, sprite ROM address width
- NUM_SCENES, 4, number of scene mask bits per sprite
- ROM_LAT, 2, cycles from sprite address out to BGR data in
- H_ACTIVE/H_FRONT/H_SYNC/H_BACK, 640/16/96/48, horizontal timing in pixels
- V_ACTIVE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33, vertical timing in lines
- BG_COLOR, 24'h150088, background BGR
- KEY_COLOR, 24'hFF00FF, transparent BGR value

Ports:
- iVGA_CLK  in  1  pixel clock
- iRST  in  1  asynchronous active-high reset
- scene_sel  in  32  current scene, from processor register $30
- cfg_we  in  1  config write strobe, one-cycle pulse, always accepted
- cfg_sprite  in  8  target sprite index
- cfg_field  in  3  0=x0, 1=y0, 2=w, 3=h, 4=scene mask
- cfg_data  in  16  write value; mask field uses low NUM_SCENES bits
- spr_addr  out  NUM_SPRITES*AW  per-sprite ROM address, sprite i at [i*AW +: AW]
- spr_bgr  in  NUM_SPRITES*24  per-sprite ROM BGR return
- oHS, oVS, oBLANK_n  out  1 each  sync and blank, aligned with colour outputs
- b_data, g_data, r_data  out  8 each  pixel colour
- frame_start  out  1  one-cycle pulse on the commit cycle

Behaviour:
- Reset: all outputs and counters clear immediately.
  - oHS=1, oVS=1, oBLANK_n=0, rgb=0, spr_addr=0, frame_start=0.
  - All shadow and active config registers = 0; a sprite with w=0 or h=0 is never visible.
  - Committed scene = 0.
- Timing counters:
  - hcnt runs 0..H_TOTAL-1 (800); vcnt increments when hcnt wraps and runs 0..V_TOTAL-1 (525).
  - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - HS is low for hcnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - VS is low for vcnt in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
- Config writes:
  - Land in shadow registers the cycle after cfg_we.
  - cfg_sprite>=NUM_SPRITES or cfg_field>4: write ignored.
- Commit:
  - Commit cycle is hcnt=H_TOTAL-1 && vcnt=V_TOTAL-1.
  - On commit, shadow copies to active registers, scene_sel is latched, and frame_start pulses.
  - A cfg_we coincident with the commit cycle updates shadow only; it is visible from the following frame.
- Hit test, stage 1 (registered), per sprite i:
  - hit_i = active && enabled_i && hcnt in [x0,x0+w) && vcnt in [y0,y0+h).
  - enabled_i = mask_i[scene] with scene<NUM_SCENES; scene>=NUM_SCENES means no sprite is enabled.
  - Bounds are compared at 17 bits, so x0+w overflow cannot wrap.
- Address:
  - On a hit: spr_addr_i = (vcnt-y0)*w + (hcnt-x0), truncated to AW.
  - On a miss: spr_addr_i holds its previous value.
- Composite stage (after ROM_LAT): output is the lowest-index layer with hit && spr_bgr_i != KEY_COLOR.
  - Otherwise BG_COLOR when active.
  - Otherwise 0 in blanking.
- Latency:
  - Colour is out ROM_LAT+2 cycles after its hcnt/vcnt (4 by default).
  - oHS, oVS, oBLANK_n pass through a matching delay line, so all outputs stay mutually aligned.
- Data format:
  - b_data=[23:16], g_data=[15:8], r_data=[7:0].
- Reset mid-frame:
  - Counters restart at (0,0); the pipeline flushes to reset values; config is lost.

Test Plan:
- Release reset, no config:
  - oHS period = 800 cycles, low for 96.
  - oVS low for 2 lines of 525.
  - Every active pixel = 150088; blanking rgb = 0.
- Sprite 0 at x0=63, y0=81, w=496, h=105, mask=0001, scene 0, ROM model returns addr as data:
  - Pixel (63,81) shows data 0.
  - Pixel (558,185) shows 52079.
  - Pixel (62,81) shows background.
  - All with latency 4.
- Sprites 0 and 1 overlapping, sprite 0 returns KEY_COLOR on even addresses:
  - Even addresses show sprite 1.
  - Odd addresses show sprite 0.
- Change x0 mid-frame:
  - Current frame unchanged.
  - Change appears from the frame after the next frame_start.
  - A write on the commit cycle itself is deferred one further frame.
- scene_sel switches 0→1 mid-frame, sprite mask=0001:
  - Sprite stays visible until commit, then disappears.
  - scene_sel=7 → background only.
- Assert iRST mid-line:
  - Outputs go immediately to reset values.
  - Config cleared.
  - First post-reset hcnt=0 pixel appears 4 cycles after release.
